// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial unsigned subtractor with a valid/ready handshake.
// Each operation subtracts one DIGIT-bit slice per clock, least significant slice first.
// A result appears N = WIDTH/DIGIT cycles after the operands are accepted.
// Optional feature: define SERIAL_SUBTRACTOR_OVF_EN to get the signed-overflow flag.
// In the default build (macro undefined) ovf is tied to 0.
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [CNT_W-1:0] cnt;

  logic [DIGIT-1:0] slice_a;
  logic [DIGIT-1:0] slice_b;
  logic [DIGIT-1:0] slice_diff;
  logic             slice_borrow;

  // One digit of subtraction; the extra top bit is the borrow out of the digit.
  function automatic logic [DIGIT:0] sub_digit(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             bi);
    return {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bi};
  endfunction

  // Select the current slice and subtract it with the running borrow,
  // which is kept in the borrow_out register while the operation runs.
  always_comb begin
    slice_a = op_a[cnt*DIGIT +: DIGIT];
    slice_b = op_b[cnt*DIGIT +: DIGIT];
    {slice_borrow, slice_diff} = sub_digit(slice_a, slice_b, borrow_out);
  end

  // Control FSM plus operand latch, digit counter and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a       <= a;
            op_b       <= b;
            borrow_out <= borrow_in;
            cnt        <= '0;
            in_ready   <= 1'b0;
            state      <= CALC;
          end
        end
        CALC: begin
          diff[cnt*DIGIT +: DIGIT] <= slice_diff;
          borrow_out               <= slice_borrow;
          if (cnt == CNT_LAST) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Borrow into the MSB recovered from the MSB sum bit: res = a ^ b ^ borrow_in.
  logic msb_borrow;
  assign msb_borrow = slice_diff[DIGIT-1] ^ slice_a[DIGIT-1] ^ slice_b[DIGIT-1];

  // Signed overflow: borrow into the MSB differs from borrow out of it on the last slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      ovf <= 1'b0;
    end else if (state == CALC && cnt == CNT_LAST) begin
      ovf <= msb_borrow ^ slice_borrow;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: a 16/4 instance for the main scenarios and
// 8/1 plus 8/8 instances for the narrow configurations, all checked against
// an arithmetic reference model.
module tb_serial_subtractor;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic        in_valid = 1'b0, in_ready, borrow_in = 1'b0, out_valid, out_ready = 1'b0;
  logic        borrow_out, ovf;
  logic [15:0] a = '0, b = '0, diff;

  logic       n1_in_valid = 1'b0, n1_in_ready, n1_borrow_in = 1'b0, n1_out_valid, n1_out_ready = 1'b0;
  logic       n1_borrow_out, n1_ovf;
  logic [7:0] n1_a = '0, n1_b = '0, n1_diff;

  logic       n8_in_valid = 1'b0, n8_in_ready, n8_borrow_in = 1'b0, n8_out_valid, n8_out_ready = 1'b0;
  logic       n8_borrow_out, n8_ovf;
  logic [7:0] n8_a = '0, n8_b = '0, n8_diff;

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid),
    .out_ready(out_ready), .diff(diff), .borrow_out(borrow_out), .ovf(ovf));

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(n1_in_valid), .in_ready(n1_in_ready),
    .a(n1_a), .b(n1_b), .borrow_in(n1_borrow_in), .out_valid(n1_out_valid),
    .out_ready(n1_out_ready), .diff(n1_diff), .borrow_out(n1_borrow_out), .ovf(n1_ovf));

  serial_subtractor #(.WIDTH(8), .DIGIT(8)) dut_n8 (
    .clk(clk), .rst_n(rst_n), .in_valid(n8_in_valid), .in_ready(n8_in_ready),
    .a(n8_a), .b(n8_b), .borrow_in(n8_borrow_in), .out_valid(n8_out_valid),
    .out_ready(n8_out_ready), .diff(n8_diff), .borrow_out(n8_borrow_out), .ovf(n8_ovf));

  // Reference model: plain integer arithmetic on the operand values.
  function automatic int ref_diff(input int w, input int x, input int y, input int bi);
    return (x - y - bi) & ((1 << w) - 1);
  endfunction

  function automatic logic ref_borrow(input int x, input int y, input int bi);
    return x < (y + bi);
  endfunction

  function automatic logic ref_ovf(input int w, input int x, input int y, input int bi);
    int sx, sy, r;
    sx = (x >= (1 << (w - 1))) ? x - (1 << w) : x;
    sy = (y >= (1 << (w - 1))) ? y - (1 << w) : y;
    r  = sx - sy - bi;
    return OVF_EN && ((r < -(1 << (w - 1))) || (r >= (1 << (w - 1))));
  endfunction

  // Drives one operation on the 16-bit instance and collects its result.
  task automatic do_op(input logic [15:0] xa, input logic [15:0] xb, input logic xbi,
                       output logic [15:0] d, output logic bo, output logic o,
                       output int lat, output logic rdy_seen);
    int g;
    g = 0;
    rdy_seen = 1'b0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    a = xa; b = xb; borrow_in = xbi; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (in_ready) rdy_seen = 1'b1;
      in_valid  = 1'($urandom);
      a         = 16'($urandom);
      b         = 16'($urandom);
      borrow_in = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    d = diff; bo = borrow_out; o = ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (diff !== 16'h0 || borrow_out !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got diff=%h bo=%b ovf=%b ov=%b exp 0000/0/0/0",
               diff, borrow_out, ovf, out_valid);
    end
    n_cmp++;
    if (n1_out_valid !== 1'b0 || n8_out_valid !== 1'b0 || n1_diff !== 8'h0 || n8_diff !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_narrow got ov=%b/%b diff=%h/%h exp 0/0 00/00",
               n1_out_valid, n8_out_valid, n1_diff, n8_diff);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || n1_in_ready !== 1'b1 || n8_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b%b%b exp 111", in_ready, n1_in_ready, n8_in_ready);
    end
  endtask

  task automatic test_basic();
    logic [15:0] d; logic bo, o, rs; int lat;
    do_op(16'h1234, 16'h0234, 1'b0, d, bo, o, lat, rs);
    n_cmp++;
    if (d !== 16'h1000) begin n_fail++; $display("FAIL basic_diff got=%h exp=1000", d); end
    n_cmp++;
    if (bo !== 1'b0) begin n_fail++; $display("FAIL basic_borrow got=%b exp=0", bo); end
    n_cmp++;
    if (lat !== 4) begin n_fail++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    n_cmp++;
    if (rs !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready got=%b exp=0 during CALC", rs); end
  endtask

  task automatic test_wrap();
    logic [15:0] d; logic bo, o, rs; int lat;
    do_op(16'h0000, 16'h0001, 1'b0, d, bo, o, lat, rs);
    n_cmp++;
    if (d !== 16'hFFFF || bo !== 1'b1) begin
      n_fail++; $display("FAIL wrap_0m1 got=%h/%b exp=ffff/1", d, bo);
    end
    do_op(16'h0000, 16'h0000, 1'b1, d, bo, o, lat, rs);
    n_cmp++;
    if (d !== 16'hFFFF || bo !== 1'b1) begin
      n_fail++; $display("FAIL wrap_borrow_in got=%h/%b exp=ffff/1", d, bo);
    end
    do_op(16'hA5C3, 16'hA5C3, 1'b0, d, bo, o, lat, rs);
    n_cmp++;
    if (d !== 16'h0000 || bo !== 1'b0) begin
      n_fail++; $display("FAIL wrap_equal got=%h/%b exp=0000/0", d, bo);
    end
  endtask

  task automatic test_ovf();
    logic [15:0] d; logic bo, o, rs; int lat;
    do_op(16'h8000, 16'h0001, 1'b0, d, bo, o, lat, rs);
    n_cmp++;
    if (d !== 16'h7FFF || bo !== 1'b0 || o !== OVF_EN) begin
      n_fail++; $display("FAIL ovf_8000 got=%h/%b/%b exp=7fff/0/%b", d, bo, o, OVF_EN);
    end
    do_op(16'h0005, 16'h0003, 1'b0, d, bo, o, lat, rs);
    n_cmp++;
    if (d !== 16'h0002 || o !== 1'b0) begin
      n_fail++; $display("FAIL ovf_5m3 got=%h/%b exp=0002/0", d, o);
    end
  endtask

  task automatic test_random();
    logic [15:0] d, xa, xb; logic bo, o, rs, xbi; int lat;
    for (int i = 0; i < 40; i++) begin
      xa = 16'($urandom); xb = 16'($urandom); xbi = 1'($urandom);
      if (i == 0) begin xa = 16'h7FFF; xb = 16'hFFFF; xbi = 1'b1; end
      do_op(xa, xb, xbi, d, bo, o, lat, rs);
      n_cmp++;
      if (d !== 16'(ref_diff(16, int'(xa), int'(xb), int'(xbi))) ||
          bo !== ref_borrow(int'(xa), int'(xb), int'(xbi)) ||
          o !== ref_ovf(16, int'(xa), int'(xb), int'(xbi)) || lat !== 4) begin
        n_fail++;
        $display("FAIL random a=%h b=%h bi=%b got=%h/%b/%b lat=%0d exp=%h/%b/%b lat=4",
                 xa, xb, xbi, d, bo, o, lat, 16'(ref_diff(16, int'(xa), int'(xb), int'(xbi))),
                 ref_borrow(int'(xa), int'(xb), int'(xbi)), ref_ovf(16, int'(xa), int'(xb), int'(xbi)));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] xa, xb, expd; int k;
    xa = 16'h4321; xb = 16'h1234;
    expd = 16'(ref_diff(16, int'(xa), int'(xb), 0));
    @(negedge clk);
    a = xa; b = xb; borrow_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = ~a; b = 16'($urandom); borrow_in = ~borrow_in;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || diff !== expd || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold cyc=%0d got ov=%b diff=%h rdy=%b exp 1/%h/0",
                 i, out_valid, diff, in_ready, expd);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL backpressure_release got ov=%b rdy=%b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d; logic bo, o, rs; int lat;
    @(negedge clk);
    a = 16'h0000; b = 16'h0001; borrow_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (diff !== 16'h0 || borrow_out !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got %h/%b/%b/%b exp 0000/0/0/0", diff, borrow_out, ovf, out_valid);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_ready got rdy=%b ov=%b exp 1/0", in_ready, out_valid);
    end
    do_op(16'h9000, 16'h0FFF, 1'b1, d, bo, o, lat, rs);
    n_cmp++;
    if (d !== 16'h8000 || bo !== 1'b0 || lat !== 4) begin
      n_fail++; $display("FAIL reset_mid_next got=%h/%b lat=%0d exp=8000/0 lat=4", d, bo, lat);
    end
  endtask

  task automatic test_back_to_back();
    int exp_d[$];
    logic exp_b[$];
    int last, accepts, ed;
    logic eb;
    last = -1; accepts = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        n_cmp++;
        if (exp_d.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected got diff=%h exp no result", diff);
        end else begin
          ed = exp_d.pop_front(); eb = exp_b.pop_front();
          if (diff !== 16'(ed) || borrow_out !== eb) begin
            n_fail++; $display("FAIL b2b_result got=%h/%b exp=%h/%b", diff, borrow_out, 16'(ed), eb);
          end
        end
      end
      if (cyc >= 32) in_valid = 1'b0;
      else if (in_ready) begin
        if (last >= 0) begin
          n_cmp++;
          if (cyc - last !== 6) begin
            n_fail++; $display("FAIL b2b_spacing got=%0d exp=6", cyc - last);
          end
        end
        last = cyc; accepts++;
        a = 16'($urandom); b = 16'($urandom); borrow_in = 1'($urandom); in_valid = 1'b1;
        exp_d.push_back(ref_diff(16, int'(a), int'(b), int'(borrow_in)));
        exp_b.push_back(ref_borrow(int'(a), int'(b), int'(borrow_in)));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (exp_d.size() != 0 || accepts < 5) begin
      n_fail++; $display("FAIL b2b_drain got pending=%0d accepts=%0d exp 0 and >=5", exp_d.size(), accepts);
    end
  endtask

  task automatic test_narrow();
    logic [7:0] x, y, d1, d8; logic bi, b1, b8, o1, o8, g1, g8; int l1, l8;
    for (int it = 0; it < 400; it++) begin
      if (it < 8) begin
        x = (it & 1) ? 8'hFF : 8'h00; y = (it & 2) ? 8'hFF : 8'h00; bi = 1'((it >> 2) & 1);
      end else begin
        x = 8'($urandom); y = 8'($urandom); bi = 1'($urandom);
      end
      @(negedge clk);
      n1_a = x; n1_b = y; n1_borrow_in = bi; n1_in_valid = 1'b1;
      n8_a = x; n8_b = y; n8_borrow_in = bi; n8_in_valid = 1'b1;
      @(posedge clk); #1;
      n1_in_valid = 1'b0; n8_in_valid = 1'b0;
      n1_a = ~x; n8_a = ~x; n1_b = 8'($urandom); n8_b = 8'($urandom);
      g1 = 0; g8 = 0; l1 = 0; l8 = 0;
      d1 = '0; d8 = '0; b1 = 0; b8 = 0; o1 = 0; o8 = 0;
      for (int k = 1; k <= 20 && !(g1 && g8); k++) begin
        @(posedge clk); #1;
        if (!g1 && n1_out_valid) begin g1 = 1; l1 = k; d1 = n1_diff; b1 = n1_borrow_out; o1 = n1_ovf; end
        if (!g8 && n8_out_valid) begin g8 = 1; l8 = k; d8 = n8_diff; b8 = n8_borrow_out; o8 = n8_ovf; end
      end
      n_cmp++;
      if (d1 !== 8'(ref_diff(8, int'(x), int'(y), int'(bi))) || b1 !== ref_borrow(int'(x), int'(y), int'(bi)) ||
          o1 !== ref_ovf(8, int'(x), int'(y), int'(bi)) || l1 !== 8) begin
        n_fail++;
        $display("FAIL narrow_d1 a=%h b=%h bi=%b got=%h/%b/%b lat=%0d exp=%h/%b/%b lat=8", x, y, bi, d1, b1, o1, l1,
                 8'(ref_diff(8, int'(x), int'(y), int'(bi))), ref_borrow(int'(x), int'(y), int'(bi)),
                 ref_ovf(8, int'(x), int'(y), int'(bi)));
      end
      n_cmp++;
      if (d8 !== 8'(ref_diff(8, int'(x), int'(y), int'(bi))) || b8 !== ref_borrow(int'(x), int'(y), int'(bi)) ||
          o8 !== ref_ovf(8, int'(x), int'(y), int'(bi)) || l8 !== 1) begin
        n_fail++;
        $display("FAIL narrow_d8 a=%h b=%h bi=%b got=%h/%b/%b lat=%0d exp=%h/%b/%b lat=1", x, y, bi, d8, b8, o8, l8,
                 8'(ref_diff(8, int'(x), int'(y), int'(bi))), ref_borrow(int'(x), int'(y), int'(bi)),
                 ref_ovf(8, int'(x), int'(y), int'(bi)));
      end
      n1_out_ready = 1'b1; n8_out_ready = 1'b1;
      @(posedge clk); #1;
      n1_out_ready = 1'b0; n8_out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_ovf();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_narrow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
